cdc_xfer_arbiter: RTL and testbench

CDC_XFER_ARBITER -- requirements
Module: cdc_xfer_arbiter

---
 rtl/cdc_xfer_arbiter.sv | 127 ++++++++++++
 tb/tb_cdc_xfer_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter
//   Collects stereo audio samples and configuration words in two pending
//   slots and sends them one at a time to another clock domain over a
//   4-phase req/ack handshake. When both slots are pending, configuration
//   goes first. A request that waits too long for ack is abandoned.
//
// Ports
//   clk, rst_n     source clock; asynchronous active-low reset
//   tick_in        audio strobe, qualifies dsp0_in (left) / dsp1_in (right)
//   cfg_in         config strobe, qualifies cfg_reg_in
//   ack_in         destination acknowledge (already synchronized to clk)
//   req_out        4-phase request level
//   data_out       payload: {dsp1,dsp0} for audio, {16'h0,cfg} for config
//   kind_out       0 = audio, 1 = config
//   busy_out       handshake in progress (FSM outside IDLE)
//   overrun_out    pulse: an unsent audio sample was replaced by a newer one
//   timeout_out    pulse: a request was abandoned without ack
module cdc_xfer_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic [23:0] dsp0_in,
    input  logic [23:0] dsp1_in,
    input  logic        cfg_in,
    input  logic [31:0] cfg_reg_in,
    input  logic        ack_in,
    output logic        req_out,
    output logic [47:0] data_out,
    output logic        kind_out,
    output logic        busy_out,
    output logic        overrun_out,
    output logic        timeout_out
);

    localparam int DATA_W = 24;
    localparam int CFG_W  = 32;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    state_t                  state;
    logic [15:0]             t_cnt;
    logic                    aud_vld;
    logic                    cfg_vld;
    logic [2*DATA_W-1:0]     aud_data;
    logic [CFG_W-1:0]        cfg_data;
    logic                    launch_aud;
    logic                    launch_cfg;

    // A launch needs the previous handshake fully released (ack low).
    // Config has fixed priority over audio.
    assign launch_cfg = (state == IDLE) && !ack_in && cfg_vld;
    assign launch_aud = (state == IDLE) && !ack_in && aud_vld && !cfg_vld;

    // Slot payloads carry no reset: they are only read behind a valid flag.
    always_ff @(posedge clk) begin
        if (tick_in) aud_data <= {dsp1_in, dsp0_in};
        if (cfg_in)  cfg_data <= cfg_reg_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            t_cnt       <= '0;
            aud_vld     <= 1'b0;
            cfg_vld     <= 1'b0;
            req_out     <= 1'b0;
            data_out    <= '0;
            kind_out    <= 1'b0;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            // A capture on the launch edge is not an overrun: the old sample
            // leaves with the launch and the new one stays pending.
            overrun_out <= tick_in && aud_vld && !launch_aud;
            timeout_out <= 1'b0;

            // Capture is written after the clear so that a same-edge
            // capture keeps the slot valid.
            if (launch_aud) aud_vld <= 1'b0;
            if (launch_cfg) cfg_vld <= 1'b0;
            if (tick_in)    aud_vld <= 1'b1;
            if (cfg_in)     cfg_vld <= 1'b1;

            case (state)
                IDLE: begin
                    if (launch_aud || launch_cfg) begin
                        state    <= REQ;
                        req_out  <= 1'b1;
                        busy_out <= 1'b1;
                        t_cnt    <= '0;
                        data_out <= launch_cfg ? {16'h0, cfg_data} : aud_data;
                        kind_out <= launch_cfg;
                    end
                end
                REQ: begin
                    if (ack_in) begin
                        state   <= WAIT_LOW;
                        req_out <= 1'b0;
                    end else if (t_cnt == TO_LAST) begin
                        // Abandoned payload is dropped, not re-queued.
                        state       <= WAIT_LOW;
                        req_out     <= 1'b0;
                        timeout_out <= 1'b1;
                    end else begin
                        t_cnt <= t_cnt + 16'd1;
                    end
                end
                WAIT_LOW: begin
                    if (!ack_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    req_out  <= 1'b0;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter
//   Drives directed and random traffic into cdc_xfer_arbiter with a delayed
//   ack echo responder. A transfer-level reference model predicts each
//   launched payload (pushed to a queue) and the per-cycle req/busy/pulse
//   outputs; a monitor on the falling edge compares against the DUT.
//   A second instance with TIMEOUT_CYCLES=16 and ack tied low covers the
//   abort path.
module tb_cdc_xfer_arbiter;

    localparam int TO_MAIN  = 255;
    localparam int TO_SHORT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        cfg = 1'b0;
    logic        ack = 1'b0;
    logic        t2_tick = 1'b0;
    logic [23:0] dsp0 = '0;
    logic [23:0] dsp1 = '0;
    logic [31:0] cfg_reg = '0;

    logic        req_out, kind_out, busy_out, overrun_out, timeout_out;
    logic [47:0] data_out;
    logic        t2_req, t2_kind, t2_busy, t2_ovr, t2_to;
    logic [47:0] t2_data;

    always #5 clk = ~clk;

    cdc_xfer_arbiter #(.TIMEOUT_CYCLES(TO_MAIN)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick), .dsp0_in(dsp0),
        .dsp1_in(dsp1), .cfg_in(cfg), .cfg_reg_in(cfg_reg), .ack_in(ack),
        .req_out(req_out), .data_out(data_out), .kind_out(kind_out),
        .busy_out(busy_out), .overrun_out(overrun_out),
        .timeout_out(timeout_out)
    );

    cdc_xfer_arbiter #(.TIMEOUT_CYCLES(TO_SHORT)) dut_t16 (
        .clk(clk), .rst_n(rst_n), .tick_in(t2_tick), .dsp0_in(dsp0),
        .dsp1_in(dsp1), .cfg_in(1'b0), .cfg_reg_in(32'h0), .ack_in(1'b0),
        .req_out(t2_req), .data_out(t2_data), .kind_out(t2_kind),
        .busy_out(t2_busy), .overrun_out(t2_ovr), .timeout_out(t2_to)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Destination responder: ack echoes req_out delayed, or is held low.
    logic [7:0] req_hist = '0;
    int         ack_dly = 2;
    bit         stall = 1'b0;
    always @(negedge clk) begin
        req_hist = {req_hist[6:0], req_out};
        ack = stall ? 1'b0 : req_hist[ack_dly];
    end

    // Reference model: two pending slots, a request phase and the number
    // of cycles the current request has been outstanding.
    bit          a_pend, c_pend;
    logic [47:0] a_dat;
    logic [31:0] c_dat;
    int          phase;       // 0 free, 1 requesting, 2 waiting for ack release
    int          held;
    bit          m_req, m_busy, m_ovr, m_to;
    logic [48:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_pend = 0; c_pend = 0; phase = 0; held = 0;
            m_ovr = 0; m_to = 0;
            exp_q.delete();
        end else begin
            m_ovr = 0;
            m_to  = 0;
            if (phase == 0) begin
                if ((a_pend || c_pend) && !ack) begin
                    if (c_pend) begin
                        exp_q.push_back({1'b1, 16'h0, c_dat});
                        c_pend = 0;
                    end else begin
                        exp_q.push_back({1'b0, a_dat});
                        a_pend = 0;
                    end
                    phase = 1;
                    held  = 0;
                end
            end else if (phase == 1) begin
                held++;
                if (ack) phase = 2;
                else if (held == TO_MAIN) begin
                    phase = 2;
                    m_to  = 1;
                end
            end else begin
                if (!ack) phase = 0;
            end
            if (tick) begin
                if (a_pend) m_ovr = 1;
                a_pend = 1;
                a_dat  = {dsp1, dsp0};
            end
            if (cfg) begin
                c_pend = 1;
                c_dat  = cfg_reg;
            end
        end
        m_req  = (phase == 1);
        m_busy = (phase != 0);
    end

    // Monitor
    logic [48:0] cur;
    logic [48:0] seen_q[$];
    bit          prev_req = 0;
    int          launches = 0;
    int          ovr_seen = 0;
    int          to_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 0;
        end else begin
            check("req_out", req_out, m_req);
            check("busy_out", busy_out, m_busy);
            check("overrun_out", overrun_out, m_ovr);
            check("timeout_out", timeout_out, m_to);
            if (overrun_out) ovr_seen++;
            if (timeout_out) to_seen++;
            if (req_out && !prev_req) begin
                launches++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL launch: got %0h, expected no transfer",
                             {kind_out, data_out});
                end else begin
                    cur = exp_q.pop_front();
                    check("payload", {kind_out, data_out}, cur);
                end
                seen_q.push_back({kind_out, data_out});
            end else if (busy_out) begin
                check("payload_hold", {kind_out, data_out}, cur);
            end
            prev_req = req_out;
        end
    end

    task automatic send_tick(input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        tick = 1'b1; dsp0 = l; dsp1 = r;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lbase;
        int obase;
        int tbase;
        int hi;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", req_out, 0);
        check("rst_data", data_out, 0);
        check("rst_kind", kind_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_ovr", overrun_out, 0);
        check("rst_to", timeout_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort path on the 16-cycle instance
        @(negedge clk);
        t2_tick = 1'b1; dsp0 = 24'h111111; dsp1 = 24'h222222;
        @(negedge clk);
        t2_tick = 1'b0;
        for (int i = 0; i < 10 && !t2_req; i++) @(negedge clk);
        hi = 0;
        while (t2_req && hi < 40) begin
            hi++;
            if (hi == 3) begin
                t2_tick = 1'b1; dsp0 = 24'h333333; dsp1 = 24'h444444;
            end else begin
                t2_tick = 1'b0;
            end
            @(negedge clk);
        end
        t2_tick = 1'b0;
        check("t2_req_cycles", hi, TO_SHORT);
        check("t2_timeout_pulse", t2_to, 1);
        check("t2_busy_wait", t2_busy, 1);
        check("t2_data_aborted", t2_data, 48'h222222111111);
        @(negedge clk);
        check("t2_idle_busy", t2_busy, 0);
        check("t2_pulse_end", t2_to, 0);
        @(negedge clk);
        check("t2_next_req", t2_req, 1);
        check("t2_next_data", t2_data, 48'h444444333333);
        check("t2_next_kind", t2_kind, 0);
        check("t2_no_overrun", t2_ovr, 0);

        // Single audio transfer
        ack_dly = 2; stall = 0;
        base = seen_q.size(); lbase = launches;
        send_tick(24'h000123, 24'hABCDEF);
        repeat (15) @(negedge clk);
        check("single_count", launches - lbase, 1);
        if (seen_q.size() > base)
            check("single_data", seen_q[base], {1'b0, 48'hABCDEF000123});
        check("single_idle", busy_out, 0);

        // Simultaneous audio and config
        base = seen_q.size();
        @(negedge clk);
        tick = 1'b1; cfg = 1'b1; cfg_reg = 32'hDEADBEEF;
        dsp0 = 24'h0A0B0C; dsp1 = 24'h0D0E0F;
        @(negedge clk);
        tick = 1'b0; cfg = 1'b0;
        repeat (25) @(negedge clk);
        check("simul_count", seen_q.size() - base, 2);
        if (seen_q.size() >= base + 2) begin
            check("simul_first", seen_q[base], {1'b1, 48'h0000DEADBEEF});
            check("simul_second", seen_q[base+1], {1'b0, 48'h0D0E0F0A0B0C});
        end

        // Overrun with ack held low for 200 cycles
        base = seen_q.size(); obase = ovr_seen; tbase = to_seen;
        stall = 1;
        send_tick(24'h000001, 24'h100000);
        repeat (4) @(negedge clk);
        send_tick(24'h000002, 24'h200000);
        repeat (4) @(negedge clk);
        send_tick(24'h000003, 24'h300000);
        repeat (186) @(negedge clk);
        stall = 0;
        repeat (30) @(negedge clk);
        check("ovr_pulses", ovr_seen - obase, 1);
        check("ovr_no_timeout", to_seen - tbase, 0);
        check("ovr_count", seen_q.size() - base, 2);
        if (seen_q.size() >= base + 2) begin
            check("ovr_first", seen_q[base], {1'b0, 48'h100000000001});
            check("ovr_second", seen_q[base+1], {1'b0, 48'h300000000003});
        end

        // Timeout on the main instance
        tbase = to_seen;
        stall = 1;
        send_tick(24'h00AAAA, 24'h00BBBB);
        repeat (280) @(negedge clk);
        check("main_timeout", to_seen - tbase, 1);
        stall = 0;
        repeat (20) @(negedge clk);

        // Reset during a request with audio pending
        stall = 1;
        send_tick(24'h0000C1, 24'h0000D1);
        repeat (4) @(negedge clk);
        send_tick(24'h0000C2, 24'h0000D2);
        @(negedge clk);
        check("pre_rst_req", req_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", req_out, 0);
        check("async_rst_busy", busy_out, 0);
        check("async_rst_data", data_out, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stall = 0;
        lbase = launches;
        repeat (20) @(negedge clk);
        check("post_rst_quiet", launches - lbase, 0);
        base = seen_q.size();
        send_tick(24'h0000C3, 24'h0000D3);
        repeat (15) @(negedge clk);
        check("post_rst_launch", launches - lbase, 1);
        if (seen_q.size() > base)
            check("post_rst_data", seen_q[base], {1'b0, 48'h0000D30000C3});

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tick    = ($urandom_range(0, 3) == 0);
            cfg     = ($urandom_range(0, 7) == 0);
            dsp0    = 24'($urandom);
            dsp1    = 24'($urandom);
            cfg_reg = $urandom;
            if (c % 100 == 0) begin
                ack_dly = $urandom_range(0, 5);
                stall   = ($urandom_range(0, 9) == 0);
            end
        end
        @(negedge clk);
        tick = 1'b0; cfg = 1'b0; stall = 0;
        repeat (50) @(negedge clk);
        check("final_idle", busy_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
